sr_drive_sequencer: RTL and testbench
=====================================

// Module: sr_drive_sequencer
// PURPOSE
//  Synchronous front-end that drives the active-low S/R inputs of the
//  cross-coupled SR latch. Turns single-cycle set/clear requests into
//  timed low pulses and guarantees s_n/r_n are never low together
//  (no forbidden state, no memory loss). After each pulse it checks the
//  latch outputs for the expected state and reports done/err to the
//  requester.
// PARAMETERS
//  PULSE_W  4  cycles s_n or r_n is held low per operation (>=1)
//  GAP_W    2  settle cycles with s_n=r_n=1 before feedback check (>=1)
//  CNT_W    4  counter width; must hold max(PULSE_W,GAP_W)
// PORTS
//  clk      in   1  single clock, rising edge
//  rst      in   1  synchronous reset, active-high
//  set_req  in   1  request latch set (Q=1); sampled when busy=0
//  clr_req  in   1  request latch clear (Q=0); sampled when busy=0
//  q_fb     in   1  latch Q output, fed back
//  qb_fb    in   1  latch QB output, fed back
//  s_n      out  1  active-low set drive to latch
//  r_n      out  1  active-low reset drive to latch
//  busy     out  1  operation in progress; requests ignored
//  done     out  1  one-cycle pulse at end of every accepted operation
//  err      out  1  one-cycle pulse: feedback mismatch or illegal request
// BEHAVIOUR
//  - Clock, reset and feedback: one clock; reset is synchronous and
//    active-high. All outputs are registered. q_fb/qb_fb are used only
//    at the check edge and are not synchronised here.
//  - Reset values: s_n=1, r_n=1, busy=0, done=0, err=0; state=IDLE;
//    counter=0. Reset mid-operation aborts. s_n/r_n return to 1 on the
//    same edge, and no done/err is produced for the aborted operation.
//  - States:
//    - IDLE, PULSE, GAP.
//    - Register op (1=set, 0=clr) captured on acceptance.
//  - IDLE:
//    - Exactly one request high at edge t -> PULSE; busy=1 from t+1.
//    - set_req & clr_req both high -> stay IDLE; err=1 for one cycle;
//      s_n/r_n stay 1; done stays 0.
//    - Neither request high -> stay IDLE.
//  - PULSE: the selected drive is low for cycles t+1 .. t+PULSE_W.
//    - set drives s_n=0; clr drives r_n=0. The other drive stays 1.
//    - After PULSE_W cycles -> GAP.
//  - GAP: s_n=r_n=1 for cycles t+PULSE_W+1 .. t+PULSE_W+GAP_W.
//    - At the last GAP edge, sample feedback. Expected (q_fb,qb_fb) is
//      (1,0) for set and (0,1) for clr.
//    - Next state is IDLE.
//  - Completion cycle t+PULSE_W+GAP_W+1:
//    - busy=0 and done=1.
//    - err=1 if feedback did not match the expected pair; (1,1) and
//      (0,0) also count as mismatches.
//  - A new request may be accepted in the completion cycle
//    (back-to-back). Its drive goes low one cycle later, so it is
//    always separated from the previous pulse by at least GAP_W
//    cycles with both drives high.
//  - Requests while busy=1 are dropped silently. There is no queue.
//  - Invariant at every edge: !(s_n==0 && r_n==0). The bench asserts it.
//  - Counter counts down from PULSE_W-1 and then GAP_W-1. There is no
//    wrap-around and no dependence on CNT_W beyond holding those values.
// TESTING  (PULSE_W=4, GAP_W=2, behavioural NAND latch model on s_n/r_n)
//  1 Reset: rst=1 for 2 cycles -> s_n=r_n=1, busy=done=err=0.
//  2 Set: set_req=1 at cycle 0 ->
//    - s_n=0 in cycles 1-4, s_n=r_n=1 in cycles 5-6.
//    - done=1 and busy=0 at cycle 7; q_fb=1; err=0.
//  3 Clear right after set: clr_req at cycle 7 ->
//    - r_n=0 in cycles 8-11.
//    - done at 14; q_fb=0, qb_fb=1; err=0.
//  4 Illegal request: set_req=clr_req=1 in IDLE ->
//    - err=1 for one cycle; done=0, busy=0.
//    - s_n=r_n=1 throughout.
//  5 Feedback fault: q_fb forced to 0 during a set ->
//    - done=1 and err=1 together at cycle 7.
//    - Also: clr_req issued at cycle 2 while busy is ignored.
//  6 Abort: rst=1 at cycle 2 of a set pulse ->
//    - s_n=1 and busy=0 from cycle 3.
//    - No done/err; the next set_req runs a full 4+2 sequence.

Source files
------------

// File: rtl/sr_drive_sequencer.sv
// Drives the active-low S/R inputs of a cross-coupled latch with timed,
// mutually exclusive pulses and checks the latch feedback afterwards.
module sr_drive_sequencer #(
   parameter int unsigned PULSE_W = 4,
   parameter int unsigned GAP_W   = 2,
   parameter int unsigned CNT_W   = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic set_req,
   input  logic clr_req,
   input  logic q_fb,
   input  logic qb_fb,
   output logic s_n,
   output logic r_n,
   output logic busy,
   output logic done,
   output logic err
);

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      GAP
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             op_q;
   logic             s_n_q;
   logic             r_n_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= 1'b0;
         s_n_q   <= 1'b1;
         r_n_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (set_req && clr_req) begin
                  err_q <= 1'b1;
               end else if (set_req || clr_req) begin
                  state_q <= PULSE;
                  op_q    <= set_req;
                  s_n_q   <= ~set_req;
                  r_n_q   <= set_req;
                  busy_q  <= 1'b1;
                  cnt_q   <= CNT_W'(PULSE_W - 1);
               end
            end
            PULSE: begin
               if (cnt_q == '0) begin
                  state_q <= GAP;
                  s_n_q   <= 1'b1;
                  r_n_q   <= 1'b1;
                  cnt_q   <= CNT_W'(GAP_W - 1);
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            GAP: begin
               if (cnt_q == '0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  // (1,1) and (0,0) fail both comparisons
                  if (op_q)
                     err_q <= ~(q_fb & ~qb_fb);
                  else
                     err_q <= ~(~q_fb & qb_fb);
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               s_n_q   <= 1'b1;
               r_n_q   <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign s_n  = s_n_q;
   assign r_n  = r_n_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// Bench for sr_drive_sequencer: behavioural NAND latch on s_n/r_n and an
// operation-timeline reference model derived from pulse/gap arithmetic.
module tb_sr_drive_sequencer;

   localparam int PW = 4;
   localparam int GW = 2;

   logic clk;
   logic rst;
   logic set_req;
   logic clr_req;
   logic q_fb;
   logic qb_fb;
   logic s_n;
   logic r_n;
   logic busy;
   logic done;
   logic err;

   logic lat;
   logic fault_en;
   logic fault_q;
   logic fault_qb;

   int n_cmp;
   int n_fail;
   int cyc;

   // reference model state
   bit       m_act;
   int       m_k;
   bit       m_op;
   logic [4:0] exp;

   sr_drive_sequencer #(
      .PULSE_W(PW),
      .GAP_W  (GW),
      .CNT_W  (4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .set_req(set_req),
      .clr_req(clr_req),
      .q_fb   (q_fb),
      .qb_fb  (qb_fb),
      .s_n    (s_n),
      .r_n    (r_n),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial lat = 1'b0;
   always @(s_n, r_n) begin
      if (s_n === 1'b0)
         lat = 1'b1;
      else if (r_n === 1'b0)
         lat = 1'b0;
   end

   assign q_fb  = fault_en ? fault_q  : lat;
   assign qb_fb = fault_en ? fault_qb : ~lat;

   always @(posedge clk) begin
      if (rst === 1'b0) begin
         n_cmp++;
         assert (!(s_n === 1'b0 && r_n === 1'b0))
         else begin
            n_fail++;
            $display("FAIL invariant cyc=%0d s_n=%b r_n=%b required not both 0",
                     cyc, s_n, r_n);
         end
      end
   end

   // One clock: drive inputs at negedge, advance the model at posedge,
   // leave outputs settled for the caller to compare.
   task automatic tick(input bit sr, input bit cr, input bit rs);
      bit fq;
      bit fqb;
      bit ok;
      @(negedge clk);
      set_req = sr;
      clr_req = cr;
      rst     = rs;
      fq      = q_fb;
      fqb     = qb_fb;
      @(posedge clk);
      cyc++;
      exp[1] = 1'b0;
      exp[0] = 1'b0;
      if (rs) begin
         m_act = 0;
         exp[4:2] = 3'b110;
      end else if (m_act) begin
         m_k++;
         if (m_k < PW) begin
            exp[4:2] = {~m_op, m_op, 1'b1};
         end else if (m_k < PW + GW) begin
            exp[4:2] = 3'b111;
         end else begin
            ok = m_op ? (fq == 1 && fqb == 0) : (fq == 0 && fqb == 1);
            exp[4:2] = 3'b110;
            exp[1] = 1'b1;
            exp[0] = !ok;
            m_act = 0;
         end
      end else if (sr && cr) begin
         exp[4:2] = 3'b110;
         exp[0] = 1'b1;
      end else if (sr || cr) begin
         m_act = 1;
         m_k = 0;
         m_op = sr;
         exp[4:2] = {~sr, sr, 1'b1};
      end else begin
         exp[4:2] = 3'b110;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         tick(0, 0, 1);
         n_cmp++;
         if ({s_n, r_n, busy, done, err} !== exp) begin
            n_fail++;
            $display("FAIL reset cyc=%0d got=%b exp=%b",
                     cyc, {s_n, r_n, busy, done, err}, exp);
         end
      end
   endtask

   task automatic test_set();
      tick(1, 0, 0);
      for (int i = 0; i <= PW + GW; i++) begin
         n_cmp++;
         if ({s_n, r_n, busy, done, err} !== exp) begin
            n_fail++;
            $display("FAIL set cyc=%0d got=%b exp=%b",
                     cyc, {s_n, r_n, busy, done, err}, exp);
         end
         if (i < PW + GW) tick(0, 0, 0);
      end
      n_cmp++;
      if (q_fb !== 1'b1) begin
         n_fail++;
         $display("FAIL set_q got=%b exp=1", q_fb);
      end
   endtask

   task automatic test_clear_after_set();
      tick(0, 1, 0);
      for (int i = 0; i <= PW + GW; i++) begin
         n_cmp++;
         if ({s_n, r_n, busy, done, err} !== exp) begin
            n_fail++;
            $display("FAIL clear cyc=%0d got=%b exp=%b",
                     cyc, {s_n, r_n, busy, done, err}, exp);
         end
         if (i < PW + GW) tick(0, 0, 0);
      end
      n_cmp++;
      if ({q_fb, qb_fb} !== 2'b01) begin
         n_fail++;
         $display("FAIL clear_q got=%b exp=01", {q_fb, qb_fb});
      end
   endtask

   task automatic test_illegal();
      tick(1, 1, 0);
      n_cmp++;
      if ({s_n, r_n, busy, done, err} !== 5'b11001) begin
         n_fail++;
         $display("FAIL illegal got=%b exp=11001",
                  {s_n, r_n, busy, done, err});
      end
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 0);
         n_cmp++;
         if ({s_n, r_n, busy, done, err} !== exp) begin
            n_fail++;
            $display("FAIL illegal_after cyc=%0d got=%b exp=%b",
                     cyc, {s_n, r_n, busy, done, err}, exp);
         end
      end
   endtask

   task automatic test_fault();
      fault_en = 1'b1;
      fault_q  = 1'b0;
      fault_qb = 1'b0;
      tick(1, 0, 0);
      for (int i = 1; i <= PW + GW + 1; i++) begin
         n_cmp++;
         if ({s_n, r_n, busy, done, err} !== exp) begin
            n_fail++;
            $display("FAIL fault cyc=%0d got=%b exp=%b",
                     cyc, {s_n, r_n, busy, done, err}, exp);
         end
         if (i <= PW + GW) tick(0, i == 2, 0);
      end
      n_cmp++;
      if ({done, err} !== 2'b11) begin
         n_fail++;
         $display("FAIL fault_done_err got=%b exp=11", {done, err});
      end
      fault_en = 1'b0;
      tick(0, 0, 0);
   endtask

   task automatic test_abort();
      tick(1, 0, 0);
      tick(0, 0, 0);
      tick(0, 0, 1);
      n_cmp++;
      if ({s_n, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL abort got=%b exp=10", {s_n, busy});
      end
      for (int i = 0; i < 4; i++) begin
         tick(0, 0, 0);
         n_cmp++;
         if ({done, err, busy, s_n} !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_quiet cyc=%0d got=%b exp=0001",
                     cyc, {done, err, busy, s_n});
         end
      end
      tick(1, 0, 0);
      for (int i = 0; i <= PW + GW; i++) begin
         n_cmp++;
         if ({s_n, r_n, busy, done, err} !== exp) begin
            n_fail++;
            $display("FAIL abort_rerun cyc=%0d got=%b exp=%b",
                     cyc, {s_n, r_n, busy, done, err}, exp);
         end
         if (i < PW + GW) tick(0, 0, 0);
      end
   endtask

   task automatic test_random();
      int r;
      bit sr;
      bit cr;
      bit rs;
      for (int i = 0; i < 400; i++) begin
         r  = int'($urandom_range(0, 99));
         sr = (r < 30) || (r >= 95);
         cr = (r >= 30 && r < 60) || (r >= 95);
         rs = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 99) < 10) begin
            fault_en = ~fault_en;
            fault_q  = 1'($urandom);
            fault_qb = 1'($urandom);
         end
         tick(sr, cr, rs);
         n_cmp++;
         if ({s_n, r_n, busy, done, err} !== exp) begin
            n_fail++;
            $display("FAIL random cyc=%0d got=%b exp=%b",
                     cyc, {s_n, r_n, busy, done, err}, exp);
         end
      end
      fault_en = 1'b0;
   endtask

   initial begin
      n_cmp    = 0;
      n_fail   = 0;
      cyc      = 0;
      m_act    = 0;
      m_k      = 0;
      m_op     = 0;
      exp      = 5'b11000;
      rst      = 1'b1;
      set_req  = 1'b0;
      clr_req  = 1'b0;
      fault_en = 1'b0;
      fault_q  = 1'b0;
      fault_qb = 1'b0;
      test_reset();
      test_set();
      test_clear_after_set();
      test_illegal();
      test_fault();
      test_abort();
      test_random();
      test_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
